dense_mac_scheduler: RTL and testbench

//   Time-multiplexed sequencer for a fixed-point dense layer. It shares one signed DW x DW multiplier
//   and one accumulator across all N_IN*N_OUT weight terms, so a layer costs one DSP.

---
 rtl/dense_mac_scheduler.sv | 148 ++++++++++++++
 tb/tb_dense_mac_scheduler.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dense_mac_scheduler.sv
// Dense-layer sequencer: one shared signed multiplier and accumulator,
// weights/biases loaded at runtime, ap_start/ap_done block handshake.
module dense_mac_scheduler #(
  parameter int N_IN       = 2,
  parameter int N_OUT      = 1,
  parameter int DW         = 16,
  parameter int FRAC_SHIFT = 10
) (
  input  logic               ap_clk,
  input  logic               ap_rst,
  input  logic               ap_start,
  output logic               ap_done,
  output logic               ap_idle,
  output logic               ap_ready,
  input  logic               input_V_ap_vld,
  input  logic [N_IN*DW-1:0] input_V,
  input  logic               cfg_we,
  input  logic [7:0]         cfg_addr,
  input  logic [DW-1:0]      cfg_wdata,
  output logic               cfg_drop,
  output logic [DW-1:0]      out_V,
  output logic               out_V_ap_vld,
  output logic [7:0]         out_idx
);

  localparam int NW   = N_IN * N_OUT;
  localparam int NCFG = NW + N_OUT;
  localparam int CW   = $clog2(NCFG);
  localparam int KW   = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int OW   = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_IN,
    MAC,
    DONE
  } state_t;

  state_t             state_q;
  logic [DW-1:0]      mem_q [NCFG];
  logic [N_IN*DW-1:0] x_q;
  logic [KW-1:0]      k_q;
  logic [OW-1:0]      o_q;
  logic [DW-1:0]      acc_q;
  logic [DW-1:0]      out_q;
  logic [7:0]         idx_q;
  logic               vld_q;
  logic               done_q;
  logic               drop_q;

  logic [CW-1:0]         widx;
  logic [CW-1:0]         bidx;
  logic signed [DW-1:0]  xk;
  logic signed [DW-1:0]  wk;
  logic signed [2*DW-1:0] prod;
  logic [DW-1:0]         term;
  logic [DW-1:0]         acc_d;
  logic                  last_k;
  logic                  last_o;
  logic                  cfg_bad;

  // Weights occupy the low addresses, biases follow in the same array.
  assign widx = CW'(int'(o_q) * N_IN + int'(k_q));
  assign bidx = CW'(NW + int'(o_q));
  assign xk   = x_q[int'(k_q)*DW +: DW];
  assign wk   = mem_q[widx];
  assign prod = xk * wk;
  assign term = DW'(prod >>> FRAC_SHIFT);

  assign acc_d   = ((k_q == '0) ? mem_q[bidx] : acc_q) + term;
  assign last_k  = (k_q == KW'(N_IN - 1));
  assign last_o  = (o_q == OW'(N_OUT - 1));
  assign cfg_bad = (cfg_addr >= 8'(NCFG));

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      k_q     <= '0;
      o_q     <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
      for (int i = 0; i < NCFG; i++) mem_q[i] <= '0;
    end else begin
      vld_q  <= 1'b0;
      done_q <= 1'b0;
      drop_q <= 1'b0;
      if (cfg_we) begin
        if (state_q != IDLE || cfg_bad) drop_q <= 1'b1;
        else mem_q[cfg_addr[CW-1:0]] <= cfg_wdata;
      end
      unique case (state_q)
        IDLE: begin
          if (ap_start) begin
            if (input_V_ap_vld) begin
              x_q     <= input_V;
              k_q     <= '0;
              o_q     <= '0;
              state_q <= MAC;
            end else begin
              state_q <= WAIT_IN;
            end
          end
        end
        WAIT_IN: begin
          if (input_V_ap_vld) begin
            x_q     <= input_V;
            k_q     <= '0;
            o_q     <= '0;
            state_q <= MAC;
          end
        end
        MAC: begin
          acc_q <= acc_d;
          if (last_k) begin
            out_q <= acc_d;
            idx_q <= 8'(o_q);
            vld_q <= 1'b1;
            k_q   <= '0;
            if (last_o) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              o_q <= o_q + OW'(1);
            end
          end else begin
            k_q <= k_q + KW'(1);
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ap_idle      = (state_q == IDLE);
  assign ap_done      = done_q;
  assign ap_ready     = done_q;
  assign cfg_drop     = drop_q;
  assign out_V        = out_q;
  assign out_V_ap_vld = vld_q;
  assign out_idx      = idx_q;

endmodule

// File: tb/tb_dense_mac_scheduler.sv
// Scoreboard bench for dense_mac_scheduler: default instance plus
// a two-neuron instance.
module tb_dense_mac_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic        rst, start, vld, we;
  logic [31:0] in_v;
  logic [7:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic        done, idle, ready, drop, out_vld;
  logic [15:0] out_v;
  logic [7:0]  out_idx;

  logic        b_start, b_vld, b_we;
  logic        b_done, b_idle, b_ready, b_drop, b_out_vld;
  logic [15:0] b_out_v;
  logic [7:0]  b_out_idx;

  dense_mac_scheduler dut (
    .ap_clk(clk), .ap_rst(rst), .ap_start(start),
    .ap_done(done), .ap_idle(idle), .ap_ready(ready),
    .input_V_ap_vld(vld), .input_V(in_v),
    .cfg_we(we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_drop(drop), .out_V(out_v), .out_V_ap_vld(out_vld),
    .out_idx(out_idx)
  );

  dense_mac_scheduler #(.N_OUT(2)) dut2 (
    .ap_clk(clk), .ap_rst(rst), .ap_start(b_start),
    .ap_done(b_done), .ap_idle(b_idle), .ap_ready(b_ready),
    .input_V_ap_vld(b_vld), .input_V(in_v),
    .cfg_we(b_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_drop(b_drop), .out_V(b_out_v), .out_V_ap_vld(b_out_vld),
    .out_idx(b_out_idx)
  );

  typedef struct {
    logic [7:0]  idx;
    logic [15:0] v;
  } exp_t;
  exp_t sbq[$];

  logic [15:0] w1 [3];
  logic [15:0] w2 [6];

  function automatic logic [15:0] term_f(logic [15:0] x, logic [15:0] w);
    logic signed [31:0] p;
    p = $signed(x) * $signed(w);
    return p[25:10];
  endfunction

  function automatic logic [15:0] neuron(logic [15:0] x0, logic [15:0] x1,
      logic [15:0] wa, logic [15:0] wb, logic [15:0] b);
    return b + term_f(x0, wa) + term_f(x1, wb);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr1(input logic [7:0] a, input logic [15:0] d);
    cfg_addr = a; cfg_wdata = d; we = 1'b1;
    tick;
    we = 1'b0;
    if (a < 3) w1[a] = d;
  endtask

  task automatic wr2(input logic [7:0] a, input logic [15:0] d);
    cfg_addr = a; cfg_wdata = d; b_we = 1'b1;
    tick;
    b_we = 1'b0;
    if (a < 6) w2[a] = d;
  endtask

  task automatic wait1(output int n);
    n = 0;
    do begin tick; n++; end while (!out_vld && n < 50);
  endtask

  task automatic wait2(output int n);
    n = 0;
    do begin tick; n++; end while (!b_out_vld && n < 50);
  endtask

  task automatic start1(input logic [15:0] x0, input logic [15:0] x1);
    in_v = {x1, x0}; start = 1'b1; vld = 1'b1;
    sbq.push_back('{8'd0, neuron(x0, x1, w1[0], w1[1], w1[2])});
    tick;
    start = 1'b0; vld = 1'b0;
  endtask

  task automatic test_reset;
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL rst_idle got %b want 1", idle); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done got %b want 0", done); end
    checks++; if (out_v !== 16'h0) begin failures++; $display("FAIL rst_out got %h want 0000", out_v); end
    checks++; if (out_vld !== 1'b0 || drop !== 1'b0) begin failures++; $display("FAIL rst_pulses got %b%b want 00", out_vld, drop); end
    checks++; if (b_idle !== 1'b1) begin failures++; $display("FAIL rst_idle2 got %b want 1", b_idle); end
  endtask

  task automatic test_basic;
    int n; exp_t e;
    wr1(0, 16'hFEE0); wr1(1, 16'd304); wr1(2, 16'd157);
    checks++; if (drop !== 1'b0) begin failures++; $display("FAIL cfg_ok_drop got %b want 0", drop); end
    start1(16'd1024, 16'd1024);
    wait1(n); e = sbq.pop_front();
    checks++; if (n !== 2) begin failures++; $display("FAIL basic_lat got %0d want 2", n); end
    checks++; if (out_v !== e.v) begin failures++; $display("FAIL basic_val got %h want %h", out_v, e.v); end
    checks++; if (out_v !== 16'd173) begin failures++; $display("FAIL basic_173 got %0d want 173", out_v); end
    checks++; if (out_idx !== e.idx) begin failures++; $display("FAIL basic_idx got %0d want %0d", out_idx, e.idx); end
    checks++; if (done !== 1'b1 || ready !== 1'b1) begin failures++; $display("FAIL basic_done got %b%b want 11", done, ready); end
    tick;
    checks++; if (done !== 1'b0 || out_vld !== 1'b0) begin failures++; $display("FAIL basic_pulse got %b%b want 00", done, out_vld); end
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL basic_idle got %b want 1", idle); end
  endtask

  task automatic test_floor;
    int n; exp_t e;
    start1(16'hFFFF, 16'hFFFF);
    wait1(n); e = sbq.pop_front();
    checks++; if (out_v !== e.v || out_v !== 16'd156) begin failures++; $display("FAIL floor_val got %0d want %0d", out_v, e.v); end
    tick;
  endtask

  task automatic test_wrap;
    int n; exp_t e;
    wr1(0, 16'd32767); wr1(1, 16'd32767); wr1(2, 16'd0);
    start1(16'd32767, 16'd32767);
    wait1(n); e = sbq.pop_front();
    checks++; if (out_v !== e.v || out_v !== 16'hFF80) begin failures++; $display("FAIL wrap_val got %h want %h", out_v, e.v); end
    tick;
  endtask

  task automatic test_wait_in;
    int n; exp_t e;
    start = 1'b1; vld = 1'b0;
    repeat (4) tick;
    start = 1'b0;
    checks++; if (idle !== 1'b0 || out_vld !== 1'b0) begin failures++; $display("FAIL wait_state got %b%b want 00", idle, out_vld); end
    in_v = {16'd2048, 16'd100}; vld = 1'b1;
    sbq.push_back('{8'd0, neuron(16'd100, 16'd2048, w1[0], w1[1], w1[2])});
    tick;
    vld = 1'b0;
    wait1(n); e = sbq.pop_front();
    checks++; if (n !== 2) begin failures++; $display("FAIL wait_lat got %0d want 2", n); end
    checks++; if (out_v !== e.v) begin failures++; $display("FAIL wait_val got %h want %h", out_v, e.v); end
    tick;
  endtask

  task automatic test_back_to_back;
    int n; exp_t e;
    wr1(0, 16'hFEE0); wr1(1, 16'd304); wr1(2, 16'd157);
    in_v = {16'd3000, 16'd700}; start = 1'b1; vld = 1'b1;
    sbq.push_back('{8'd0, neuron(16'd700, 16'd3000, w1[0], w1[1], w1[2])});
    sbq.push_back('{8'd0, neuron(16'hF000, 16'd5, w1[0], w1[1], w1[2])});
    tick;
    in_v = {16'd5, 16'hF000};
    wait1(n); e = sbq.pop_front();
    checks++; if (out_v !== e.v) begin failures++; $display("FAIL b2b_val1 got %h want %h", out_v, e.v); end
    wait1(n); e = sbq.pop_front();
    start = 1'b0; vld = 1'b0;
    checks++; if (n !== 4) begin failures++; $display("FAIL b2b_gap got %0d want 4", n); end
    checks++; if (out_v !== e.v) begin failures++; $display("FAIL b2b_val2 got %h want %h", out_v, e.v); end
    tick;
  endtask

  task automatic test_cfg_drop;
    int n; exp_t e; logic [15:0] first;
    start1(16'd1500, 16'hFC00);
    cfg_addr = 8'd0; cfg_wdata = 16'd1234; we = 1'b1;
    tick;
    we = 1'b0;
    checks++; if (drop !== 1'b1) begin failures++; $display("FAIL drop_busy got %b want 1", drop); end
    wait1(n); e = sbq.pop_front();
    checks++; if (n !== 1 || out_v !== e.v) begin failures++; $display("FAIL drop_val1 got %h want %h", out_v, e.v); end
    first = e.v;
    tick;
    cfg_addr = 8'd200; cfg_wdata = 16'd999; we = 1'b1;
    tick;
    we = 1'b0;
    checks++; if (drop !== 1'b1) begin failures++; $display("FAIL drop_addr got %b want 1", drop); end
    tick;
    checks++; if (drop !== 1'b0) begin failures++; $display("FAIL drop_pulse got %b want 0", drop); end
    start1(16'd1500, 16'hFC00);
    wait1(n); e = sbq.pop_front();
    checks++; if (out_v !== e.v || out_v !== first) begin failures++; $display("FAIL drop_val2 got %h want %h", out_v, e.v); end
    tick;
  endtask

  task automatic test_two_out;
    int n; exp_t e;
    wr2(0, 16'd1024); wr2(1, 16'd1024); wr2(2, 16'd1024);
    wr2(3, 16'd0); wr2(4, 16'd0); wr2(5, 16'd0);
    in_v = {16'd20, 16'd500}; b_start = 1'b1; b_vld = 1'b1;
    sbq.push_back('{8'd0, neuron(16'd500, 16'd20, w2[0], w2[1], w2[4])});
    sbq.push_back('{8'd1, neuron(16'd500, 16'd20, w2[2], w2[3], w2[5])});
    tick;
    b_start = 1'b0; b_vld = 1'b0;
    wait2(n); e = sbq.pop_front();
    checks++; if (n !== 2) begin failures++; $display("FAIL two_lat0 got %0d want 2", n); end
    checks++; if (b_out_idx !== e.idx || b_out_v !== e.v) begin failures++; $display("FAIL two_n0 got %0d/%h want %0d/%h", b_out_idx, b_out_v, e.idx, e.v); end
    checks++; if (b_done !== 1'b0) begin failures++; $display("FAIL two_early_done got %b want 0", b_done); end
    wait2(n); e = sbq.pop_front();
    checks++; if (n !== 2) begin failures++; $display("FAIL two_lat1 got %0d want 2", n); end
    checks++; if (b_out_idx !== e.idx || b_out_v !== 16'd500 || b_out_v !== e.v) begin failures++; $display("FAIL two_n1 got %0d/%h want %0d/%h", b_out_idx, b_out_v, e.idx, e.v); end
    checks++; if (b_done !== 1'b1 || b_ready !== 1'b1) begin failures++; $display("FAIL two_done got %b%b want 11", b_done, b_ready); end
    tick;
  endtask

  task automatic test_rst_mid;
    int n; int dones; exp_t e;
    in_v = {16'd1024, 16'd1024}; start = 1'b1; vld = 1'b1;
    tick;
    start = 1'b0; vld = 1'b0;
    tick;
    rst = 1'b1;
    #1;
    checks++; if (idle !== 1'b1 || out_v !== 16'h0) begin failures++; $display("FAIL rstmid_state got %b/%h want 1/0000", idle, out_v); end
    tick;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) w1[i] = 16'h0;
    dones = 0;
    for (int i = 0; i < 5; i++) begin tick; if (done) dones++; end
    checks++; if (dones !== 0) begin failures++; $display("FAIL rstmid_done got %0d want 0", dones); end
    start1(16'd1024, 16'd1024);
    wait1(n); e = sbq.pop_front();
    checks++; if (out_v !== e.v) begin failures++; $display("FAIL rstmid_wlost got %h want %h", out_v, e.v); end
    tick;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; vld = 1'b0; we = 1'b0;
    b_start = 1'b0; b_vld = 1'b0; b_we = 1'b0;
    in_v = '0; cfg_addr = '0; cfg_wdata = '0;
    for (int i = 0; i < 3; i++) w1[i] = 16'h0;
    for (int i = 0; i < 6; i++) w2[i] = 16'h0;
    tick; tick;
    rst = 1'b0;
    #1;
    test_reset;
    test_basic;
    test_floor;
    test_wrap;
    test_wait_in;
    test_back_to_back;
    test_cfg_drop;
    test_two_out;
    test_rst_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
